// File: rtl/nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : nibble_serial_addsub_ctrl
//  Purpose  : Two-requester arbiter and sequencer that runs a 4*NIBBLES-bit
//             add/subtract through a shared 4-bit slice, one nibble per cycle,
//             and returns a registered result with carry and overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
module nibble_serial_addsub_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic [4*NIBBLES-1:0]   a0,
  input  logic [4*NIBBLES-1:0]   b0,
  input  logic                   sub0,
  input  logic                   req1,
  input  logic [4*NIBBLES-1:0]   a1,
  input  logic [4*NIBBLES-1:0]   b1,
  input  logic                   sub1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   busy,
  output logic                   done,
  output logic                   owner,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int W  = 4 * NIBBLES;
  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] C_LAST_NIB = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;        // operand A, shifted right one nibble per CALC cycle
  logic [W-1:0]    b_q, b_d;        // operand B, shifted in step with A
  logic [W-1:0]    acc_q, acc_d;    // sum nibbles enter at the top and shift down
  logic            sub_q, sub_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            a_msb_q, a_msb_d;   // A[W-1], kept for the overflow flag
  logic            bp_msb_q, bp_msb_d; // (B ^ sub)[W-1], kept for the overflow flag
  logic            last_q, last_d;     // requester served most recently
  logic            gnt0_q, gnt0_d;
  logic            gnt1_q, gnt1_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            owner_q, owner_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [4:0]      slice_sum;
  logic            pick;

  // Next-state, arbitration and shared-slice datapath
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    bp_msb_d = bp_msb_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done_d   = 1'b0;
    owner_d  = owner_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    pick     = 1'b0;

    // The slice always looks at the lowest nibble of the shifting operands.
    slice_sum = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0] ^ {4{sub_q}}} + {4'b0000, carry_q};

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins; otherwise the lone one.
          pick     = (req0 && req1) ? ~last_q : req1;
          a_d      = pick ? a1 : a0;
          b_d      = pick ? b1 : b0;
          sub_d    = pick ? sub1 : sub0;
          carry_d  = pick ? sub1 : sub0;
          a_msb_d  = pick ? a1[W-1] : a0[W-1];
          bp_msb_d = pick ? (b1[W-1] ^ sub1) : (b0[W-1] ^ sub0);
          cnt_d    = '0;
          last_d   = pick;
          gnt0_d   = ~pick;
          gnt1_d   = pick;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d   = (acc_q >> 4) | (W'(slice_sum[3:0]) << (W - 4));
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = slice_sum[4];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == C_LAST_NIB) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle publishes the result; the second (done high) exits.
        if (!done_q) begin
          result_d = acc_q;
          cout_d   = carry_q;
          ovf_d    = (a_msb_q == bp_msb_q) && (acc_q[W-1] != a_msb_q);
          owner_d  = last_q;
          done_d   = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      bp_msb_q <= 1'b0;
      last_q   <= 1'b1;  // makes requester 0 win the first tie after reset
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      owner_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      bp_msb_q <= bp_msb_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      owner_q  <= owner_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign owner  = owner_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_addsub_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nibble_serial_addsub_ctrl
//  Purpose  : Self-checking bench for nibble_serial_addsub_ctrl: vector table,
//             scoreboard of expected results, arbitration and reset sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nibble_serial_addsub_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         clk, rst_n;
  logic         req0, sub0, req1, sub1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, owner, cout, ovf;
  logic [W-1:0] result;

  nibble_serial_addsub_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0), .sub0(sub0),
    .req1(req1), .a1(a1), .b1(b1), .sub1(sub1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .owner(owner),
    .result(result), .cout(cout), .ovf(ovf)
  );

  typedef struct {
    logic         owner;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic         rq;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } vec_t;

  exp_t sb[$];
  logic gnt_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent full-width reference: integer arithmetic for the signed flag.
  function automatic exp_t model(input logic own, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub);
    exp_t e;
    logic [W:0] full;
    int sa, sbv, sr;
    full = sub ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    sa   = int'($signed(a));
    sbv  = int'($signed(b));
    sr   = sub ? (sa - sbv) : (sa + sbv);
    e.owner = own;
    e.res   = full[W-1:0];
    e.cout  = sub ? (a >= b) : full[W];
    e.ovf   = (sr > (2**(W-1) - 1)) || (sr < -(2**(W-1)));
    return e;
  endfunction

  // Output monitor: grant rules, done latency and scoreboard comparison
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (gnt0 || gnt1) begin
        check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
        check("busy_with_gnt", 32'(busy), 32'd1);
        gnt_cyc = cyc;
        gnt_log.push_back(gnt1);
      end
      if (done) begin
        check("done_latency", 32'(cyc - gnt_cyc), 32'(NIBBLES + 1));
        check("busy_with_done", 32'(busy), 32'd1);
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("owner", 32'(owner), 32'(e.owner));
          check("result", 32'(result), 32'(e.res));
          check("cout", 32'(cout), 32'(e.cout));
          check("ovf", 32'(ovf), 32'(e.ovf));
        end
      end
    end
  end

  task automatic set_ops(input logic rq, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sub);
    if (rq) begin a1 = a; b1 = b; sub1 = sub; end
    else    begin a0 = a; b0 = b; sub0 = sub; end
  endtask

  task automatic wait_gnt(input logic rq, output logic got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rq ? gnt1 : gnt0) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_done(output logic got);
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
  endtask

  task automatic check_all_zero(input string name);
    check(name, 32'({gnt0, gnt1, busy, done, owner, cout, ovf}), 32'd0);
    check({name, "_result"}, 32'(result), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    logic got;
    sb.push_back('{owner: v.rq, res: v.res, cout: v.cout, ovf: v.ovf});
    set_ops(v.rq, v.a, v.b, v.sub);
    if (v.rq) req1 = 1'b1; else req0 = 1'b1;
    wait_gnt(v.rq, got);
    req0 = 1'b0;
    req1 = 1'b0;
    check("gnt_seen", 32'(got), 32'd1);
    wait_done(got);
    check("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    check("busy_fall", 32'(busy), 32'd0);
    check("result_held", 32'(result), 32'(v.res));
  endtask

  vec_t vecs[11];

  initial begin
    logic got;
    int   done_c, gnt1_c, ng, ndone;
    logic who;
    logic exp_order[4];
    exp_t e;

    vecs[0]  = '{1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; sub0 = 1'b0;
    a1 = '0; b1 = '0; sub1 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single-requester operations
    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Request arriving mid-operation waits for the first IDLE edge
    set_ops(1'b0, 16'h4321, 16'h1111, 1'b1);
    set_ops(1'b1, 16'h00FF, 16'h0F01, 1'b0);
    sb.push_back(model(1'b0, a0, b0, sub0));
    req0 = 1'b1;
    wait_gnt(1'b0, got);
    req0 = 1'b0;
    check("busy_gnt0_seen", 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk);
    sb.push_back(model(1'b1, a1, b1, sub1));
    req1 = 1'b1;
    done_c = -100;
    gnt1_c = 100;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) done_c = cyc;
      if (gnt1) begin gnt1_c = cyc; break; end
    end
    req1 = 1'b0;
    check("gnt1_after_done", 32'(gnt1_c - done_c), 32'd2);
    wait_done(got);
    check("busy_done1_seen", 32'(got), 32'd1);
    @(negedge clk);

    // Contention: both held, last served was requester 1
    set_ops(1'b0, 16'h1111, 16'h2222, 1'b0);
    set_ops(1'b1, 16'h9000, 16'h1000, 1'b1);
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (exp_order[i]) sb.push_back(model(1'b1, a1, b1, sub1));
      else              sb.push_back(model(1'b0, a0, b0, sub0));
    end
    gnt_log.delete();
    req0 = 1'b1;
    req1 = 1'b1;
    ng = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        ng++;
        if (ng == 4) break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("contention_grants", 32'(ng), 32'd4);
    wait_done(got);
    check("contention_done", 32'(got), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < gnt_log.size()) check("grant_order", 32'(gnt_log[i]), 32'(exp_order[i]));
      else                    check("grant_order_missing", 32'(gnt_log.size()), 32'd4);
    end
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    // Reset while nibble 2 is being computed
    set_ops(1'b0, 16'h1357, 16'h2468, 1'b0);
    sb.push_back(model(1'b0, a0, b0, sub0));
    req0 = 1'b1;
    wait_gnt(1'b0, got);
    req0 = 1'b0;
    check("midrst_gnt_seen", 32'(got), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero("after_midrst");
    if (sb.size() > 0) e = sb.pop_back();
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_reset", 32'(ndone), 32'd0);

    // First tie after reset goes to requester 0
    set_ops(1'b1, 16'h0001, 16'h0001, 1'b0);
    sb.push_back(model(1'b0, a0, b0, sub0));
    req0 = 1'b1;
    req1 = 1'b1;
    who = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin who = gnt1; got = 1'b1; break; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    check("tie_after_reset_seen", 32'(got), 32'd1);
    check("tie_after_reset_winner", 32'(who), 32'd0);
    wait_done(got);
    check("post_reset_done", 32'(got), 32'd1);
    @(negedge clk);
    check("final_sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_addsub_ctrl.md
# nibble_serial_addsub_ctrl

Sequencer and arbiter for the team's 4-bit ripple add/subtract slice. It shares one nibble-wide add/sub datapath between two requesters and runs a 4*NIBBLES-bit addition or subtraction one nibble per cycle. Between nibbles it carries the slice carry in a flip-flop. It sits between the operand sources and the shared adder and returns a registered result with carry and signed-overflow flags.

## Interface
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; minimum 1
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- req0  in  1  requester 0 operation request; held until gnt0
- a0, b0  in  W  requester 0 operands
- sub0  in  1  requester 0 operation: 0 = a+b, 1 = a-b
- req1, a1, b1, sub1  in  1/W/W/1  requester 1, same meaning as requester 0
- gnt0, gnt1  out  1  one-cycle pulse: request accepted and operands captured
- busy  out  1  operation in progress, including the DONE cycle
- done  out  1  one-cycle pulse: result, cout and ovf are valid
- owner  out  1  index of the requester served by the current or last operation
- result  out  W  final sum or difference, held until the next done
- cout  out  1  final carry out; for subtract, 1 = no borrow (a >= b unsigned)
- ovf  out  1  two's-complement signed overflow of the full-width operation

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- IDLE:
  - If any req is high at a clock edge, grant one requester, capture its a, b and sub into internal registers, load the carry register with sub, clear the nibble counter, and go to CALC.
  - If exactly one req is high, that requester is granted.
  - If both are high, round-robin: grant the requester not served last. After reset, requester 0 wins the first tie.
- CALC, once per cycle for nibble k = 0..NIBBLES-1:
  - slice computes s = A[4k+3:4k] + (B[4k+3:4k] ^ {4{sub}}) + carry
  - s[3:0] is written to the accumulator nibble k; carry <= s[4]; counter increments
  - After nibble NIBBLES-1, go to DONE.
- DONE:
  - result <= accumulator; cout <= final carry; ovf <= (A[W-1] == B'[W-1]) && (sum[W-1] != A[W-1]), where B' = B ^ {W{sub}}
  - done pulses, then the state returns to IDLE.
- Width rules:
  - All arithmetic is modulo 2^W.
  - Only the last slice's carry is exported.
  - Intermediate nibbles never appear on result.
- gnt0 and gnt1 are never high together, and neither is ever high while an operation is already in progress.
- Requests seen in CALC or DONE are ignored; they are arbitrated again only from IDLE.
- A req still high after its grant is treated as a new request.
- Synchronous reset in any state, including mid-CALC:
  - returns to IDLE
  - no done pulse
  - all outputs, the carry register, the counter and the round-robin pointer go to their reset values.
- Reset values: gnt0 = 0, gnt1 = 0, busy = 0, done = 0, owner = 0, result = 0, cout = 0, ovf = 0.

## Timing
- Let E be the acceptance edge in IDLE. gnt and busy are high in the cycle after E; gnt lasts exactly one cycle.
- Nibble k is computed at edge E+1+k.
- done is high in the cycle after edge E+NIBBLES+1, i.e. exactly NIBBLES+1 cycles after the gnt cycle. result, cout, ovf and owner are valid from that cycle and are held until the next DONE.
- busy falls when IDLE is re-entered, one cycle after done.
- The earliest next acceptance edge is E+NIBBLES+3, so throughput is one operation per NIBBLES+3 cycles.
- All outputs are registered; no combinational path runs from req or operand inputs to any output.

## Test plan
- Add, requester 0 only: a0 = 0x1234, b0 = 0x0FFF, sub0 = 0 -> gnt0 pulse; done 5 cycles after gnt0; result = 0x2233, cout = 0, ovf = 0, owner = 0.
- Subtract, requester 1 only: a1 = 0x0005, b1 = 0x0007, sub1 = 1 -> gnt1 pulse; result = 0xFFFE, cout = 0, ovf = 0, owner = 1. Then a1 = 0x0007, b1 = 0x0005 -> result = 0x0002, cout = 1.
- Flag boundaries, each a separate operation:
  - 0x7FFF + 0x0001 -> result = 0x8000, ovf = 1, cout = 0
  - 0xFFFF + 0x0001 -> result = 0x0000, cout = 1, ovf = 0
  - 0x8000 - 0x0001 -> result = 0x7FFF, ovf = 1, cout = 1
- Contention: req0 and req1 both held high for 4 operations -> grant order 0, 1, 0, 1; never both gnt high; each done matches its owner's operands.
- Busy-time request: req1 rises during the CALC of requester 0's operation -> no gnt1 until after done; gnt1 appears at the first IDLE edge.
- Reset mid-operation: rst_n low for one edge at nibble 2 of an add -> no done; all outputs 0 the next cycle; a new req0 is then served normally, with requester 0 winning the first tie.
